mips_run_monitor: RTL and testbench

Parametrised run-control and observation unit for the single-cycle MIPS core. It sits beside the `MIPS` instance, samples the retiring PC/instruction and the V0/A0 register values, and detects program exit (V0 == exit code). On exit it captures A0 as the program result; if no exit occurs within a cycle budget, it flags a timeout. A circular trace buffer holds the most recent retired instructions, so the halt-and-report behaviour lives in synthesisable RTL instead of bench-only code.

---
 rtl/mips_mon_pkg.sv | 20 ++
 rtl/mips_run_monitor_if.sv | 44 ++++
 rtl/mips_mon_trace_buf.sv | 72 +++++++
 rtl/mips_run_monitor.sv | 102 ++++++++++
 tb/tb_mips_run_monitor.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_mon_pkg.sv
// Shared encodings, defaults and helpers for the MIPS run monitor.
// Imported by the monitor top, its interface and the trace buffer.
package mips_mon_pkg;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HALT    = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    localparam int DEFAULT_EXIT_CODE = 10;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } trace_entry_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mips_run_monitor_if.sv
// Retire/observation bus between the MIPS core side and the run monitor.
// The master drives retirement samples and the trace index; the slave reports status.
interface mips_run_monitor_if #(
    parameter int DATA_W      = 32,
    parameter int PC_W        = 32,
    parameter int TRACE_DEPTH = 16
);
    localparam int IDX_W = $clog2(TRACE_DEPTH);

    logic              clear_i;
    logic              instr_valid_i;
    logic [PC_W-1:0]   pc_i;
    logic [31:0]       instr_i;
    logic [DATA_W-1:0] v0_i;
    logic [DATA_W-1:0] a0_i;
    logic [IDX_W-1:0]  trace_rd_idx_i;

    logic [1:0]        state_o;
    logic              halted_o;
    logic              timeout_o;
    logic [DATA_W-1:0] result_o;
    logic [31:0]       cycle_count_o;
    logic [31:0]       instr_count_o;
    logic [IDX_W:0]    trace_count_o;
    logic [PC_W-1:0]   trace_rd_pc_o;
    logic [31:0]       trace_rd_instr_o;

    modport master (
        output clear_i, instr_valid_i, pc_i, instr_i,
        output v0_i, a0_i, trace_rd_idx_i,
        input  state_o, halted_o, timeout_o, result_o,
        input  cycle_count_o, instr_count_o, trace_count_o,
        input  trace_rd_pc_o, trace_rd_instr_o
    );

    modport slave (
        input  clear_i, instr_valid_i, pc_i, instr_i,
        input  v0_i, a0_i, trace_rd_idx_i,
        output state_o, halted_o, timeout_o, result_o,
        output cycle_count_o, instr_count_o, trace_count_o,
        output trace_rd_pc_o, trace_rd_instr_o
    );

endinterface

// File: rtl/mips_mon_trace_buf.sv
// Circular trace of recently retired {pc, instr} pairs.
// Saturating fill count; registered read indexed back from the newest entry.
module mips_mon_trace_buf #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            wr_en_i,
    input  logic [PC_W-1:0] wr_pc_i,
    input  logic [31:0]     wr_instr_i,
    input  logic [AW-1:0]   rd_idx_i,
    output logic [AW:0]     count_o,
    output logic [PC_W-1:0] rd_pc_o,
    output logic [31:0]     rd_instr_o
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    entry_t          mem_q [DEPTH];
    entry_t          rd_q, rd_d;
    logic [AW-1:0]   wp_q, wp_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [AW-1:0]   rd_ptr;
    logic            rd_hit;

    assign rd_ptr = wp_q - AW'(1) - rd_idx_i;
    assign rd_hit = {1'b0, rd_idx_i} < cnt_q;

    always_comb begin
        wp_d  = wp_q;
        cnt_d = cnt_q;
        rd_d  = rd_hit ? mem_q[rd_ptr] : '0;
        if (clear_i) begin
            wp_d  = '0;
            cnt_d = '0;
        end else if (wr_en_i) begin
            wp_d  = wp_q + AW'(1);
            cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp_q  <= '0;
            cnt_q <= '0;
            rd_q  <= '0;
        end else begin
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
        end
    end

    // Storage needs no reset: reads are gated by the fill count.
    always_ff @(posedge clock) begin
        if (wr_en_i && !clear_i)
            mem_q[wp_q] <= '{pc: wr_pc_i, instr: wr_instr_i};
    end

    assign count_o    = cnt_q;
    assign rd_pc_o    = rd_q.pc;
    assign rd_instr_o = rd_q.instr;

endmodule

// File: rtl/mips_run_monitor.sv
// Run-control monitor for the single-cycle MIPS core: exit/timeout FSM and counters.
// Trace buffer is built only when MIPS_MON_TRACE_EN is defined.
module mips_run_monitor
    import mips_mon_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int PC_W           = 32,
    parameter int TRACE_DEPTH    = 16,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int EXIT_CODE      = DEFAULT_EXIT_CODE
) (
    input logic              clock,
    input logic              reset,
    mips_run_monitor_if.slave mon
);

    localparam int          IDX_W   = $clog2(TRACE_DEPTH);
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    logic [1:0]        state_q, state_d;
    logic [31:0]       cyc_q, cyc_d;
    logic [31:0]       icnt_q, icnt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              exit_hit;
    logic              to_hit;
    logic              wr_en;

    assign exit_hit = (mon.v0_i == DATA_W'(EXIT_CODE));
    assign to_hit   = TO_EN && (cyc_q == TO_LAST);
    assign wr_en    = mon.instr_valid_i && (state_q == ST_RUN) && !mon.clear_i;

    // Exit outranks timeout on the same edge; counting still happens on it.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        icnt_d   = icnt_q;
        result_d = result_q;
        if (mon.clear_i) begin
            state_d = ST_RUN;
            cyc_d   = '0;
            icnt_d  = '0;
        end else if (state_q == ST_RUN) begin
            cyc_d = sat_inc32(cyc_q);
            if (mon.instr_valid_i)
                icnt_d = sat_inc32(icnt_q);
            if (exit_hit) begin
                state_d  = ST_HALT;
                result_d = mon.a0_i;
            end else if (to_hit) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            cyc_q    <= '0;
            icnt_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            icnt_q   <= icnt_d;
            result_q <= result_d;
        end
    end

    assign mon.state_o       = state_q;
    assign mon.halted_o      = (state_q == ST_HALT);
    assign mon.timeout_o     = (state_q == ST_TIMEOUT);
    assign mon.result_o      = result_q;
    assign mon.cycle_count_o = cyc_q;
    assign mon.instr_count_o = icnt_q;

`ifdef MIPS_MON_TRACE_EN
    mips_mon_trace_buf #(
        .PC_W  (PC_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (mon.clear_i),
        .wr_en_i    (wr_en),
        .wr_pc_i    (mon.pc_i),
        .wr_instr_i (mon.instr_i),
        .rd_idx_i   (mon.trace_rd_idx_i),
        .count_o    (mon.trace_count_o),
        .rd_pc_o    (mon.trace_rd_pc_o),
        .rd_instr_o (mon.trace_rd_instr_o)
    );
`else
    logic unused_trace;
    assign unused_trace = ^{wr_en, mon.pc_i, mon.instr_i, mon.trace_rd_idx_i};

    assign mon.trace_count_o    = '0;
    assign mon.trace_rd_pc_o    = '0;
    assign mon.trace_rd_instr_o = '0;
`endif

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor: reset, exit, trace wrap, clear, timeout.
// Trace expectations collapse to 0 when MIPS_MON_TRACE_EN is undefined.
module tb_mips_run_monitor;
    import mips_mon_pkg::*;

    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;

    mips_run_monitor_if #(.DATA_W(32), .PC_W(32), .TRACE_DEPTH(4)) mif ();

    mips_run_monitor #(
        .DATA_W         (32),
        .PC_W           (32),
        .TRACE_DEPTH    (4),
        .TIMEOUT_CYCLES (50),
        .EXIT_CODE      (10)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .mon   (mif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         clr;
        logic         vld;
        logic [31:0]  pc;
        logic [31:0]  ins;
        logic [31:0]  v0;
        logic [31:0]  a0;
        logic [1:0]   idx;
        logic [1:0]   st;
        logic [31:0]  cyc;
        logic [31:0]  icnt;
        logic [31:0]  res;
        logic [2:0]   tc;
        trace_entry_t rd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic clr, input logic vld,
        input logic [31:0] pc, input logic [31:0] ins,
        input logic [31:0] v0, input logic [31:0] a0,
        input logic [1:0] idx, input logic [1:0] st,
        input logic [31:0] cyc, input logic [31:0] icnt,
        input logic [31:0] res, input logic [2:0] tc,
        input logic [31:0] rpc, input logic [31:0] rins
    );
        vec_t v;
        v.clr = clr; v.vld = vld; v.pc = pc; v.ins = ins;
        v.v0 = v0; v.a0 = a0; v.idx = idx; v.st = st;
        v.cyc = cyc; v.icnt = icnt; v.res = res; v.tc = tc;
        v.rd.pc = rpc; v.rd.instr = rins;
        return v;
    endfunction

    function automatic logic [63:0] tr(input logic [63:0] x);
`ifdef MIPS_MON_TRACE_EN
        return x;
`else
        return (x & 64'd0);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic vld,
                         input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] v0, input logic [31:0] a0,
                         input logic [1:0] idx);
        mif.clear_i        = clr;
        mif.instr_valid_i  = vld;
        mif.pc_i           = pc;
        mif.instr_i        = ins;
        mif.v0_i           = v0;
        mif.a0_i           = a0;
        mif.trace_rd_idx_i = idx;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_core(input string tag, input logic [1:0] st,
                            input logic [31:0] cyc, input logic [31:0] icnt,
                            input logic [31:0] res);
        chk({tag, ".state"}, 64'(mif.state_o), 64'(st));
        chk({tag, ".halted"}, 64'(mif.halted_o), 64'(st == ST_HALT));
        chk({tag, ".timeout"}, 64'(mif.timeout_o), 64'(st == ST_TIMEOUT));
        chk({tag, ".cycles"}, 64'(mif.cycle_count_o), 64'(cyc));
        chk({tag, ".instrs"}, 64'(mif.instr_count_o), 64'(icnt));
        chk({tag, ".result"}, 64'(mif.result_o), 64'(res));
    endtask

    task automatic chk_trace(input string tag, input logic [2:0] tc,
                             input logic [31:0] rpc, input logic [31:0] rins);
        chk({tag, ".tcount"}, 64'(mif.trace_count_o), tr(64'(tc)));
        chk({tag, ".rd_pc"}, 64'(mif.trace_rd_pc_o), tr(64'(rpc)));
        chk({tag, ".rd_instr"}, 64'(mif.trace_rd_instr_o), tr(64'(rins)));
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        //        clr vld pc  ins     v0  a0  idx st cyc icnt res tc rpc rins
        vt.push_back(mk(0, 1, 0,  'h100, 0,  0,  0, 0, 1,  1,  0,  1, 0,  0));
        vt.push_back(mk(0, 1, 4,  'h101, 0,  0,  0, 0, 2,  2,  0,  2, 0,  'h100));
        vt.push_back(mk(0, 0, 0,  0,     0,  0,  2, 0, 3,  2,  0,  2, 0,  0));
        vt.push_back(mk(0, 0, 0,  0,     0,  0,  1, 0, 4,  2,  0,  2, 0,  'h100));
        vt.push_back(mk(0, 1, 8,  'h102, 0,  0,  0, 0, 5,  3,  0,  3, 4,  'h101));
        vt.push_back(mk(0, 1, 12, 'h103, 0,  0,  0, 0, 6,  4,  0,  4, 8,  'h102));
        vt.push_back(mk(0, 1, 16, 'h104, 0,  0,  0, 0, 7,  5,  0,  4, 12, 'h103));
        vt.push_back(mk(0, 1, 20, 'h105, 0,  0,  0, 0, 8,  6,  0,  4, 16, 'h104));
        vt.push_back(mk(0, 0, 0,  0,     0,  0,  0, 0, 9,  6,  0,  4, 20, 'h105));
        vt.push_back(mk(0, 0, 0,  0,     0,  0,  1, 0, 10, 6,  0,  4, 16, 'h104));
        vt.push_back(mk(0, 0, 0,  0,     0,  0,  2, 0, 11, 6,  0,  4, 12, 'h103));
        vt.push_back(mk(0, 0, 0,  0,     0,  0,  3, 0, 12, 6,  0,  4, 8,  'h102));
        vt.push_back(mk(0, 1, 24, 'h106, 0,  0,  0, 0, 13, 7,  0,  4, 20, 'h105));
        vt.push_back(mk(0, 1, 28, 'h107, 10, 42, 0, 1, 14, 8,  42, 4, 24, 'h106));
        vt.push_back(mk(0, 1, 32, 'h108, 10, 99, 1, 1, 14, 8,  42, 4, 24, 'h106));

        // reset values while held in reset
        #12;
        chk_core("rst", ST_RUN, 0, 0, 0);
        chk_trace("rst", 0, 0, 0);

        // reset asserted mid-run after 5 retirements
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 32'(i * 4), 32'h200 + 32'(i), 0, 0, 0);
            step();
        end
        chk("run5.instrs", 64'(mif.instr_count_o), 64'd5);
        chk("run5.cycles", 64'(mif.cycle_count_o), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_core("arst", ST_RUN, 0, 0, 0);
        chk_trace("arst", 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;

        // trace wrap, read latency and exit
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].clr, vt[i].vld, vt[i].pc, vt[i].ins,
                  vt[i].v0, vt[i].a0, vt[i].idx);
            step();
            chk_core($sformatf("vec%0d", i), vt[i].st, vt[i].cyc,
                     vt[i].icnt, vt[i].res);
            chk_trace($sformatf("vec%0d", i), vt[i].tc,
                      vt[i].rd.pc, vt[i].rd.instr);
        end

        // HALT is sticky for 20 more retiring cycles
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 32'h40 + 32'(i * 4), 32'h300, 0, 55, 0);
            step();
        end
        chk_core("frozen", ST_HALT, 14, 8, 42);
        chk("frozen.tcount", 64'(mif.trace_count_o), tr(64'd4));

        // clear with a simultaneous retirement that must be dropped
        drive(1, 1, 32'h99, 32'h999, 0, 77, 0);
        step();
        chk_core("clr", ST_RUN, 0, 0, 42);
        chk("clr.tcount", 64'(mif.trace_count_o), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk_trace("clr1", 0, 0, 0);

        // timeout at edge 50
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 3, 0, 0);
        repeat (49) step();
        chk_core("to49", ST_RUN, 49, 0, 42);
        step();
        chk_core("to50", ST_TIMEOUT, 50, 0, 42);
        repeat (5) step();
        chk_core("to55", ST_TIMEOUT, 50, 0, 42);

        // exit on edge 50 beats timeout
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (49) step();
        drive(0, 1, 32'h1C8, 32'h0C, 10, 7, 0);
        step();
        chk_core("tie50", ST_HALT, 50, 1, 7);
        drive(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
